// File: rtl/synth_key_pkg.sv
`default_nettype none
// ============================================================================
// synth_key_pkg : shared types and widths for the key event encoder
// Revision      : 1.0
// ============================================================================
package synth_key_pkg;

  localparam int NUM_KEYS_CFG = 8;
  localparam int KEY_IDX_W    = $clog2(NUM_KEYS_CFG);
  localparam int KEY_CNT_W    = $clog2(NUM_KEYS_CFG + 1);

  typedef struct packed {
    logic [KEY_IDX_W-1:0] idx;
    logic                 press;
  } key_evt_t;

endpackage : synth_key_pkg
`default_nettype wire

// File: rtl/key_event_encoder_if.sv
`default_nettype none
// ============================================================================
// key_event_encoder_if : valid/ready event stream carrying key press/release
// Revision             : 1.0
// ============================================================================
interface key_event_encoder_if #(
  parameter int NUM_KEYS = 8
);
  logic                        evt_valid;
  logic                        evt_ready;
  logic [$clog2(NUM_KEYS)-1:0] evt_key;
  logic                        evt_press;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_press,
    output evt_ready
  );
endinterface : key_event_encoder_if
`default_nettype wire

// File: rtl/key_evt_fifo.sv
`default_nettype none
// ============================================================================
// key_evt_fifo : synchronous show-ahead FIFO of key events
// Revision     : 1.0
// ============================================================================
module key_evt_fifo
  import synth_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  key_evt_t din,
  output logic     full,
  input  logic     pop,
  output key_evt_t dout,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  key_evt_t         mem_q [DEPTH];
  key_evt_t         mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule : key_evt_fifo
`default_nettype wire

// File: rtl/key_event_encoder.sv
`default_nettype none
// ============================================================================
// key_event_encoder : turns debounced key levels into buffered press/release events
// Revision          : 1.0
// ============================================================================
module key_event_encoder
  import synth_key_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_CFG,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_KEYS-1:0]    key_level,
  key_event_encoder_if.master    evt_if,
  output logic [KEY_CNT_W-1:0]   held_count
);

  logic [NUM_KEYS-1:0]  reported_q, reported_d;
  logic [NUM_KEYS-1:0]  pending;
  logic [KEY_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [KEY_IDX_W-1:0] pick_idx;
  logic                 pick_found;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  key_evt_t             fifo_din;
  key_evt_t             fifo_dout;
  logic [KEY_CNT_W-1:0] held_count_q, held_count_d;

  // A key that returns to its reported level before service simply drops out.
  assign pending = key_level ^ reported_q;

  // Round-robin search starting one past the last serviced key.
  always_comb begin
    int                   j;
    logic [KEY_IDX_W-1:0] cand;
    j          = 0;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_KEYS) begin
        j = j - NUM_KEYS;
      end
      cand = j[KEY_IDX_W-1:0];
      if (!pick_found && pending[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pop  = !fifo_empty && evt_if.evt_ready;
  assign push = pick_found && (!fifo_full || pop);

  assign fifo_din.idx   = pick_idx;
  assign fifo_din.press = key_level[pick_idx];

  always_comb begin
    reported_d = reported_q;
    rr_ptr_d   = rr_ptr_q;
    if (push) begin
      reported_d[pick_idx] = key_level[pick_idx];
      rr_ptr_d             = pick_idx;
    end
  end

  always_comb begin
    held_count_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      held_count_d = held_count_d + {{(KEY_CNT_W-1){1'b0}}, reported_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reported_q   <= '0;
      rr_ptr_q     <= KEY_IDX_W'(NUM_KEYS - 1);
      held_count_q <= '0;
    end else begin
      reported_q   <= reported_d;
      rr_ptr_q     <= rr_ptr_d;
      held_count_q <= held_count_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero when empty so reset values appear immediately.
  assign evt_if.evt_valid = !fifo_empty;
  assign evt_if.evt_key   = fifo_empty ? '0 : fifo_dout.idx;
  assign evt_if.evt_press = fifo_empty ? 1'b0 : fifo_dout.press;
  assign held_count       = held_count_q;

endmodule : key_event_encoder
`default_nettype wire
